bcd_stopwatch_ctrl: RTL and testbench
=====================================

# bcd_stopwatch_ctrl

Controller for a cascade of decade (mod-10) counters forming an N-digit BCD stopwatch. It converts single-cycle start/stop, lap and clear requests plus a periodic tick into count-enable and clear sequencing for the digit chain. It also holds a lap snapshot for display and flags wrap-around. It sits between the button/tick front end and the seven-segment display driver.

## Interface
- NUM_DIGITS, 4, number of cascaded decade digits (1..8)
- clk  in  1  single clock; all state changes on rising edge
- clr  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle count-enable pulse (time base)
- start_stop  in  1  one-cycle request: toggle run/pause
- lap  in  1  one-cycle request: freeze/release displayed value
- clear_req  in  1  one-cycle request: zero the count (effective only in PAUSE)
- digits  out  4*NUM_DIGITS  displayed BCD value, digit 0 in bits [3:0] (least significant)
- running  out  1  high in RUN or LAP_RUN
- frozen  out  1  high in LAP_RUN
- overflow  out  1  sticky wrap flag
- carry_out  out  1  one-cycle pulse on wrap from all-9s to all-0s

## Operation
- States: IDLE, RUN, PAUSE, LAP_RUN. Reset state IDLE.
- Request priority in a cycle: clear_req (where effective) > start_stop > lap. Requests that have no effect in the current state are dropped, not queued.
- IDLE:
  - start_stop -> RUN.
  - lap and clear_req are ignored.
- RUN:
  - start_stop -> PAUSE.
  - else lap -> LAP_RUN; hold register loads the current registered count (pre-increment value, even if tick is high that cycle).
  - clear_req is ignored.
- LAP_RUN:
  - start_stop -> PAUSE; display released.
  - else lap -> RUN; display released.
  - clear_req is ignored.
- PAUSE:
  - clear_req -> IDLE; count zeroed, overflow cleared.
  - else start_stop -> RUN.
  - lap is ignored.
- Counting:
  - Enabled when the registered state is RUN or LAP_RUN and tick=1. Decided by the current state, not the next state: a tick coinciding with start_stop in RUN still counts; in IDLE/PAUSE it does not.
  - Increment is BCD ripple-carry. Digit k advances only when tick=1 and digits 0..k-1 are all 9.
  - A digit at 9 with carry-in goes to 0. No digit ever holds 10-15.
- Wrap: all digits at 9 plus enabled tick -> all digits 0, overflow set (sticky), carry_out pulses. Counting continues.
- digits = hold register in LAP_RUN, else live count.

## Timing
- Reset (clr=0 at an edge): state IDLE, count 0, hold 0, digits 0, running 0, frozen 0, overflow 0, carry_out 0. Reset overrides all inputs; mid-count reset zeroes on that edge.
- Count latency: digits reflect an enabled tick one cycle after the tick cycle (registered count).
- State outputs (running, frozen) are decoded from the registered state and change on the edge that samples the request.
- carry_out: high for exactly the one cycle following the wrapping edge. overflow rises in the same cycle.
- Back-to-back requests on consecutive cycles are each evaluated against the updated state.

## Structure
- Shared package: state enum (IDLE, RUN, PAUSE, LAP_RUN), BCD digit width constant (4), BCD max constant (9).
- Sub-module decade_digit:
  - Synchronous mod-10 counter with enable, synchronous active-low clear, carry-out = enable and value==9.
  - Instantiated NUM_DIGITS times in a generate chain.
- The FSM, hold register and output mux live in the top module.

## Test plan
- Reset then 12 ticks in IDLE -> digits stays 0x0000, running=0.
- start_stop, 25 ticks -> digits 0x0025, running=1. Then start_stop -> running=0; further ticks leave 0x0025.
- RUN at 0x0019, lap coincident with tick -> frozen=1, digits shows 0x0019. 5 more ticks shown frozen; lap again -> digits 0x0025.
- Preload by running to 0x9998, then 2 ticks -> 0x9999 then 0x0000; carry_out one-cycle pulse, overflow=1 persists.
- PAUSE with clear_req and start_stop in the same cycle -> IDLE, digits 0x0000, overflow 0.
- clr low mid-count at 0x0437 while in LAP_RUN -> next cycle all outputs 0, state IDLE. clear_req in RUN is ignored.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit chain.
package bcd_stopwatch_ctrl_pkg;
    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        LAP_RUN = 2'd3
    } sw_state_e;
endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Request/display bundle between the button/tick front end and the stopwatch controller.
interface bcd_stopwatch_ctrl_if
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                                tick;
    logic                                start_stop;
    logic                                lap;
    logic                                clear_req;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]    digits;
    logic                                running;
    logic                                frozen;
    logic                                overflow;
    logic                                carry_out;

    modport master (
        output tick, start_stop, lap, clear_req,
        input  digits, running, frozen, overflow, carry_out
    );

    modport slave (
        input  tick, start_stop, lap, clear_req,
        output digits, running, frozen, overflow, carry_out
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl_decade_digit.sv
// One mod-10 stage of the stopwatch count chain; carry asserts on an enabled 9.
module decade_digit
    import bcd_stopwatch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] value,
    output logic             co
);
    logic [BCD_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (en) value_d = (value_q == BCD_MAX) ? '0 : value_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clr) value_q <= '0;
        else      value_q <= value_d;
    end

    assign value = value_q;
    assign co    = en && (value_q == BCD_MAX);
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear sequencing over a chain of decade digits,
// with a lap snapshot register and a sticky wrap flag.
module bcd_stopwatch_ctrl
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4
)(
    input  logic                 clk,
    input  logic                 clr,
    bcd_stopwatch_ctrl_if.slave  sw
);
    sw_state_e                         state_q, state_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]  count;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]  hold_q, hold_d;
    logic [NUM_DIGITS-1:0]             dig_en;
    logic [NUM_DIGITS-1:0]             dig_co;
    logic                              count_en, zero_count, digit_clr;
    logic                              overflow_q, overflow_d;
    logic                              carry_out_q, carry_out_d;
    logic                              unused_co;

    // Count enable comes from the registered state, so a tick that lands with
    // a stop request still counts.
    assign count_en = sw.tick && (state_q == RUN || state_q == LAP_RUN);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        zero_count = 1'b0;
        case (state_q)
            IDLE:    if (sw.start_stop) state_d = RUN;
            RUN: begin
                if (sw.start_stop) state_d = PAUSE;
                else if (sw.lap) begin
                    state_d = LAP_RUN;
                    hold_d  = count;
                end
            end
            LAP_RUN: begin
                if (sw.start_stop) state_d = PAUSE;
                else if (sw.lap)   state_d = RUN;
            end
            PAUSE: begin
                if (sw.clear_req) begin
                    state_d    = IDLE;
                    zero_count = 1'b1;
                end else if (sw.start_stop) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ripple enables are derived from registered digit values rather than the
    // digit carry outputs, keeping the chain free of combinational feedback.
    always_comb begin
        dig_en[0] = count_en;
        for (int k = 1; k < NUM_DIGITS; k++)
            dig_en[k] = dig_en[k-1] && (count[k-1] == BCD_MAX);
    end

    assign digit_clr   = clr && !zero_count;
    assign carry_out_d = dig_co[NUM_DIGITS-1];
    assign overflow_d  = zero_count ? 1'b0 : (overflow_q || dig_co[NUM_DIGITS-1]);
    assign unused_co   = ^dig_co;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        decade_digit u_digit (
            .clk   (clk),
            .clr   (digit_clr),
            .en    (dig_en[g]),
            .value (count[g]),
            .co    (dig_co[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            overflow_q  <= overflow_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign sw.digits    = (state_q == LAP_RUN) ? hold_q : count;
    assign sw.running   = (state_q == RUN) || (state_q == LAP_RUN);
    assign sw.frozen    = (state_q == LAP_RUN);
    assign sw.overflow  = overflow_q;
    assign sw.carry_out = carry_out_q;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl: a decimal-integer model predicts every cycle.
module tb_bcd_stopwatch_ctrl;
    localparam int ND   = 4;
    localparam int MAXV = 10 ** ND;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;
    // stimulus vector {rst, tick, start_stop, lap, clear_req}
    localparam logic [4:0] R = 5'b10000, T = 5'b01000, SS = 5'b00100,
                           LP = 5'b00010, CR = 5'b00001, NO = 5'b00000;

    typedef logic [4*ND+3:0] obs_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    bcd_stopwatch_ctrl_if #(.NUM_DIGITS(ND)) sw();
    bcd_stopwatch_ctrl #(.NUM_DIGITS(ND)) dut (.clk(clk), .clr(clr), .sw(sw));

    obs_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_st = S_IDLE, m_cnt = 0, m_hold = 0;
    bit   m_ovf = 0, m_co = 0;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic obs_t observe();
        return {sw.digits, sw.running, sw.frozen, sw.overflow, sw.carry_out};
    endfunction

    // Drive one cycle of requests, advance the model, queue its prediction.
    task automatic step(input logic [4:0] v);
        bit en;
        int st_n;
        clr = !v[4]; sw.tick = v[3]; sw.start_stop = v[2]; sw.lap = v[1]; sw.clear_req = v[0];
        if (v[4]) begin
            m_st = S_IDLE; m_cnt = 0; m_hold = 0; m_ovf = 0; m_co = 0;
        end else begin
            en   = v[3] && (m_st == S_RUN || m_st == S_LAP);
            m_co = en && (m_cnt == MAXV - 1);
            st_n = m_st;
            case (m_st)
                S_IDLE: if (v[2]) st_n = S_RUN;
                S_RUN: begin
                    if (v[2]) st_n = S_PAUSE;
                    else if (v[1]) begin st_n = S_LAP; m_hold = m_cnt; end
                end
                S_LAP: begin
                    if (v[2]) st_n = S_PAUSE;
                    else if (v[1]) st_n = S_RUN;
                end
                default: begin
                    if (v[0]) begin st_n = S_IDLE; m_cnt = 0; m_ovf = 0; end
                    else if (v[2]) st_n = S_RUN;
                end
            endcase
            if (en) begin
                m_cnt = (m_cnt + 1) % MAXV;
                if (m_co) m_ovf = 1;
            end
            m_st = st_n;
        end
        sb.push_back({(m_st == S_LAP) ? to_bcd(m_hold) : to_bcd(m_cnt),
                      1'(m_st == S_RUN || m_st == S_LAP), 1'(m_st == S_LAP), m_ovf, m_co});
        @(posedge clk); #1;
        clr = 1'b1; sw.tick = 0; sw.start_stop = 0; sw.lap = 0; sw.clear_req = 0;
    endtask

    task automatic test_reset();
        logic [4:0] v[3] = '{R, T, T | LP | CR};
        int         n[3] = '{2, 12, 1};
        obs_t got, exp;
        for (int i = 0; i < 3; i++) repeat (n[i]) begin
            step(v[i]); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_chk++;
        if (sw.digits !== 16'h0000 || sw.running !== 1'b0)
            $display("FAIL idle_ticks digits=%h running=%b exp 0000/0", sw.digits, sw.running);
        else n_pass++;
    endtask

    task automatic test_run_pause();
        logic [4:0] v[4] = '{SS, T, SS, T};
        int         n[4] = '{1, 25, 1, 5};
        obs_t got, exp;
        for (int i = 0; i < 4; i++) repeat (n[i]) begin
            step(v[i]); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) $display("FAIL run_pause[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_chk++;
        if (sw.digits !== 16'h0025 || sw.running !== 1'b0)
            $display("FAIL paused_hold digits=%h running=%b exp 0025/0", sw.digits, sw.running);
        else n_pass++;
    endtask

    task automatic test_lap();
        logic [4:0] v[4] = '{CR, SS, T, T | LP};
        int         n[4] = '{1, 1, 19, 1};
        logic [4:0] w[2] = '{T, LP};
        int         m[2] = '{5, 1};
        obs_t got, exp;
        for (int i = 0; i < 4; i++) repeat (n[i]) begin
            step(v[i]); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) $display("FAIL lap_in[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_chk++;
        if (sw.digits !== 16'h0019 || sw.frozen !== 1'b1)
            $display("FAIL lap_freeze digits=%h frozen=%b exp 0019/1", sw.digits, sw.frozen);
        else n_pass++;
        for (int i = 0; i < 2; i++) repeat (m[i]) begin
            step(w[i]); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) $display("FAIL lap_out[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_chk++;
        if (sw.digits !== 16'h0025 || sw.frozen !== 1'b0 || sw.running !== 1'b1)
            $display("FAIL lap_release digits=%h frozen=%b exp 0025/0", sw.digits, sw.frozen);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [4:0] v[5] = '{SS, CR, SS, T, T};
        int         n[5] = '{1, 1, 1, 9998, 1};
        obs_t got, exp;
        for (int i = 0; i < 5; i++) repeat (n[i]) begin
            step(v[i]); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) $display("FAIL wrap_pre[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_chk++;
        if (sw.digits !== 16'h9999 || sw.carry_out !== 1'b0)
            $display("FAIL all_nines digits=%h carry=%b exp 9999/0", sw.digits, sw.carry_out);
        else n_pass++;
        step(T); got = observe(); exp = sb.pop_front(); n_chk++;
        if (got !== exp || got !== {16'h0000, 4'b1011})
            $display("FAIL wrap_edge got=%h exp=%h", got, {16'h0000, 4'b1011});
        else n_pass++;
        step(NO); got = observe(); exp = sb.pop_front(); n_chk++;
        if (got !== exp || sw.carry_out !== 1'b0 || sw.overflow !== 1'b1)
            $display("FAIL wrap_after got=%h exp=%h", got, exp);
        else n_pass++;
        step(T); got = observe(); exp = sb.pop_front(); n_chk++;
        if (got !== exp || sw.digits !== 16'h0001)
            $display("FAIL wrap_continue got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        obs_t got, exp;
        step(SS); got = observe(); exp = sb.pop_front(); n_chk++;
        if (got !== exp) $display("FAIL to_pause got=%h exp=%h", got, exp);
        else n_pass++;
        step(SS | CR); got = observe(); exp = sb.pop_front(); n_chk++;
        if (got !== exp || got !== {16'h0000, 4'b0000})
            $display("FAIL clear_prio got=%h exp=%h", got, {16'h0000, 4'b0000});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] v[9] = '{SS, SS, SS, T | SS, SS, T | CR, LP, LP | SS, SS};
        obs_t got, exp;
        for (int i = 0; i < 9; i++) begin
            step(v[i]); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_chk++;
        if (sw.digits !== 16'h0002 || sw.running !== 1'b1 || sw.frozen !== 1'b0)
            $display("FAIL b2b_final digits=%h running=%b exp 0002/1", sw.digits, sw.running);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [4:0] v[7] = '{SS, CR, SS, T, LP, T, R | T | SS};
        int         n[7] = '{1, 1, 1, 437, 1, 3, 1};
        obs_t got, exp;
        for (int i = 0; i < 7; i++) repeat (n[i]) begin
            if (i == 6) begin
                n_chk++;
                if (sw.digits !== 16'h0437 || sw.frozen !== 1'b1)
                    $display("FAIL lap_at_437 digits=%h frozen=%b exp 0437/1", sw.digits, sw.frozen);
                else n_pass++;
            end
            step(v[i]); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp) $display("FAIL reset_mid[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        n_chk++;
        if (observe() !== '0) $display("FAIL reset_zero got=%h exp=%h", observe(), obs_t'(0));
        else n_pass++;
        repeat (2) begin
            step(T); got = observe(); exp = sb.pop_front(); n_chk++;
            if (got !== exp || sw.digits !== 16'h0000)
                $display("FAIL post_reset_idle got=%h exp=%h", got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        sw.tick = 0; sw.start_stop = 0; sw.lap = 0; sw.clear_req = 0;
        @(posedge clk); #1;
        test_reset();
        test_run_pause();
        test_lap();
        test_wrap();
        test_clear_priority();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
